// File: rtl/difficulty_select_ctrl.sv
// difficulty_select_ctrl: button front end and game-phase FSM that produce
// the CPU difficulty setting from the raw BTNL/BTNC/BTNR pins.
// Build option: define DIFFICULTY_DEBOUNCE_EN to include the per-button
// debounce counters; without it the synchronizer output is used as the
// stable button level directly.
//
// state  | meaning
// -------+-------------------------------------------------------------
// MENU   | waiting for a selection, difficulty_valid low
// ARMED  | selection latched, presses may still change it
// LOCKED | game in progress, presses ignored, difficulty frozen
// OVER   | game finished, a press re-arms, return to menu on abort
module difficulty_select_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        btn_l,
    input  logic        btn_c,
    input  logic        btn_r,
    input  logic [31:0] game_state,
    output logic [31:0] difficulty,
    output logic        difficulty_valid,
    output logic [2:0]  btn_press,
    output logic [1:0]  phase
);

    typedef enum logic [1:0] {
        ST_MENU   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_LOCKED = 2'd2,
        ST_OVER   = 2'd3
    } state_t;

    logic [2:0] btn_raw;
    logic [2:0] meta_q, sync_q;
    logic [2:0] stable;
    logic [2:0] stable_prev_q, stable_prev_d;
    logic [2:0] press_q, press_d;

    state_t     state_q, state_d;
    logic [1:0] diff_q, diff_d;
    logic       valid_q, valid_d;
    logic [1:0] sel_diff;
    logic       any_press;
    logic [1:0] gs;

    // bit order matches btn_press: {r, c, l}
    assign btn_raw = {btn_r, btn_c, btn_l};

    // two-flop synchronizer for the asynchronous button pins
    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= btn_raw;
            sync_q <= meta_q;
        end
    end

`ifdef DIFFICULTY_DEBOUNCE_EN
    logic [2:0]            stable_q, stable_d;
    logic [2:0][CNT_W-1:0] cnt_q, cnt_d;

    // count consecutive cycles of disagreement; accept the new level on the last one
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        for (int i = 0; i < 3; i++) begin
            if (sync_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    stable_d[i] = sync_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // debounce state registers
    always_ff @(posedge clock) begin
        if (reset) begin
            stable_q <= '0;
            cnt_q    <= '0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;
`else
    logic [CNT_W-1:0] unused_cfg;

    assign unused_cfg = CNT_W'(DEBOUNCE_CYCLES);
    assign stable     = sync_q;
`endif

    // rising edge of the stable level becomes a one-cycle press pulse
    always_comb begin
        stable_prev_d = stable;
        press_d       = stable & ~stable_prev_q;
    end

    // edge-detect and pulse registers
    always_ff @(posedge clock) begin
        if (reset) begin
            stable_prev_q <= '0;
            press_q       <= '0;
        end else begin
            stable_prev_q <= stable_prev_d;
            press_q       <= press_d;
        end
    end

    // fixed priority L > C > R when pulses coincide
    always_comb begin
        sel_diff = 2'd3;
        if (press_q[0]) begin
            sel_diff = 2'd1;
        end else if (press_q[1]) begin
            sel_diff = 2'd2;
        end
    end

    assign any_press = |press_q;
    assign gs        = game_state[1:0];

    // next-state and selection latching; game_state value 3 behaves as menu
    always_comb begin
        state_d = state_q;
        diff_d  = diff_q;
        valid_d = valid_q;
        unique case (state_q)
            ST_MENU: begin
                if (any_press) begin
                    diff_d  = sel_diff;
                    valid_d = 1'b1;
                    state_d = ST_ARMED;
                end else if (gs == 2'd1) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_ARMED: begin
                if (any_press) begin
                    diff_d  = sel_diff;
                    valid_d = 1'b1;
                end
                if (gs == 2'd1) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (gs == 2'd2) begin
                    state_d = ST_OVER;
                end else if (gs != 2'd1) begin
                    state_d = ST_MENU;
                    valid_d = 1'b0;
                end
            end
            ST_OVER: begin
                if (any_press) begin
                    diff_d  = sel_diff;
                    valid_d = 1'b1;
                    state_d = ST_ARMED;
                end else if (gs == 2'd0 || gs == 2'd3) begin
                    state_d = ST_MENU;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_MENU;
            end
        endcase
    end

    // FSM state and selection registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_MENU;
            diff_q  <= 2'd1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            diff_q  <= diff_d;
            valid_q <= valid_d;
        end
    end

    // game_state bits above [1:0] carry no meaning here
    logic unused_gs;
    assign unused_gs = ^game_state[31:2];

    assign difficulty       = {30'd0, diff_q};
    assign difficulty_valid = valid_q;
    assign btn_press        = press_q;
    assign phase            = state_q;

endmodule

// File: tb/tb_difficulty_select_ctrl.sv
// Bench for difficulty_select_ctrl: directed scenarios plus random button and
// game_state activity, compared every cycle with a window-based reference.
module tb_difficulty_select_ctrl;

    localparam int N_DEB = 4;
`ifdef DIFFICULTY_DEBOUNCE_EN
    localparam int LAT = N_DEB + 2;
`else
    localparam int LAT = 2;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        btn_l = 1'b0;
    logic        btn_c = 1'b0;
    logic        btn_r = 1'b0;
    logic [31:0] game_state = 32'd0;
    logic [31:0] difficulty;
    logic        difficulty_valid;
    logic [2:0]  btn_press;
    logic [1:0]  phase;

    difficulty_select_ctrl #(
        .DEBOUNCE_CYCLES(N_DEB),
        .CNT_W          (3)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .btn_l           (btn_l),
        .btn_c           (btn_c),
        .btn_r           (btn_r),
        .game_state      (game_state),
        .difficulty      (difficulty),
        .difficulty_valid(difficulty_valid),
        .btn_press       (btn_press),
        .phase           (phase)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // reference: raw sample history per button, newest at index 0
    bit         samp [3][N_DEB+1];
    bit         st_m [3];
    bit         rose_m [3];
    logic [2:0] press_m;
    int         ph_m;
    int         diff_m;
    bit         val_m;

    task automatic model_edge();
        logic [2:0] raw;
        logic [1:0] gs;
        bit         any;
        int         sel;
        bit         nst;
        bit         all_diff;
        raw = {btn_r, btn_c, btn_l};
        gs  = game_state[1:0];
        if (reset) begin
            for (int b = 0; b < 3; b++) begin
                for (int k = 0; k <= N_DEB; k++) samp[b][k] = 1'b0;
                st_m[b]   = 1'b0;
                rose_m[b] = 1'b0;
            end
            press_m = 3'b000;
            ph_m    = 0;
            diff_m  = 1;
            val_m   = 1'b0;
        end else begin
            any = (press_m != 3'b000);
            sel = press_m[0] ? 1 : (press_m[1] ? 2 : 3);
            case (ph_m)
                0: begin
                    if (any) begin diff_m = sel; val_m = 1'b1; ph_m = 1; end
                    else if (gs == 2'd1) ph_m = 2;
                end
                1: begin
                    if (any) begin diff_m = sel; val_m = 1'b1; end
                    if (gs == 2'd1) ph_m = 2;
                end
                2: begin
                    if (gs == 2'd2) ph_m = 3;
                    else if (gs != 2'd1) begin ph_m = 0; val_m = 1'b0; end
                end
                default: begin
                    if (any) begin diff_m = sel; val_m = 1'b1; ph_m = 1; end
                    else if (gs == 2'd0 || gs == 2'd3) begin ph_m = 0; val_m = 1'b0; end
                end
            endcase
            press_m = {rose_m[2], rose_m[1], rose_m[0]};
            for (int b = 0; b < 3; b++) begin
`ifdef DIFFICULTY_DEBOUNCE_EN
                all_diff = 1'b1;
                for (int k = 1; k <= N_DEB; k++)
                    if (samp[b][k] == st_m[b]) all_diff = 1'b0;
                nst = all_diff ? ~st_m[b] : st_m[b];
`else
                all_diff = 1'b0;
                nst = samp[b][0];
`endif
                rose_m[b] = nst && !st_m[b];
                st_m[b]   = nst;
                for (int k = N_DEB; k >= 1; k--) samp[b][k] = samp[b][k-1];
                samp[b][0] = raw[b];
            end
        end
    endtask

    int step_no;
    int pcnt [3];
    int first_pulse;

    task automatic clear_counts();
        step_no     = 0;
        first_pulse = -1;
        for (int b = 0; b < 3; b++) pcnt[b] = 0;
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check("difficulty", difficulty, diff_m);
        check("valid", {31'd0, difficulty_valid}, {31'd0, val_m});
        check("phase", {30'd0, phase}, ph_m);
        check("btn_press", {29'd0, btn_press}, {29'd0, press_m});
        for (int b = 0; b < 3; b++) begin
            if (btn_press[b]) begin
                pcnt[b]++;
                if (first_pulse < 0) first_pulse = step_no;
            end
        end
        step_no++;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_diff"}, difficulty, 32'd1);
        check({tag, "_valid"}, {31'd0, difficulty_valid}, 32'd0);
        check({tag, "_phase"}, {30'd0, phase}, 32'd0);
        check({tag, "_press"}, {29'd0, btn_press}, 32'd0);
    endtask

    initial begin
        clear_counts();
        // reset and idle
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(10);
        check_reset_outputs("rst_idle");

        // hold C in MENU
        clear_counts();
        btn_c = 1'b1;
        idle(20);
        check("holdc_pulses", pcnt[1], 1);
        check("holdc_latency", first_pulse, LAT);
        check("holdc_diff", difficulty, 32'd2);
        check("holdc_phase", {30'd0, phase}, 32'd1);
        check("holdc_valid", {31'd0, difficulty_valid}, 32'd1);
        btn_c = 1'b0;
        idle(10);

        // glitchy R: 3 high, 1 low
        clear_counts();
        repeat (5) begin
            btn_r = 1'b1; idle(3);
            btn_r = 1'b0; idle(1);
        end
        idle(10);
`ifdef DIFFICULTY_DEBOUNCE_EN
        check("glitch_pulses", pcnt[2], 0);
        check("glitch_diff", difficulty, 32'd2);
`endif

        // L and R together in ARMED
        btn_l = 1'b1; btn_r = 1'b1;
        idle(10);
        btn_l = 1'b0; btn_r = 1'b0;
        idle(10);
        check("lr_diff", difficulty, 32'd1);

        // playing locks the selection
        game_state = 32'd1;
        idle(3);
        check("lock_phase", {30'd0, phase}, 32'd2);
        btn_r = 1'b1; idle(10);
        btn_r = 1'b0; idle(10);
        check("lock_diff", difficulty, 32'd1);

        game_state = 32'd2;
        idle(3);
        check("over_phase", {30'd0, phase}, 32'd3);

        // press in OVER re-arms
        btn_r = 1'b1; idle(10);
        btn_r = 1'b0; idle(10);
        check("over_press_diff", difficulty, 32'd3);
        check("over_press_phase", {30'd0, phase}, 32'd1);

        // abort from OVER to MENU
        game_state = 32'd1; idle(3);
        game_state = 32'd2; idle(3);
        game_state = 32'd0; idle(3);
        check("abort_phase", {30'd0, phase}, 32'd0);
        check("abort_valid", {31'd0, difficulty_valid}, 32'd0);
        check("abort_diff", difficulty, 32'd3);

        // reset while LOCKED with C held
        game_state = 32'd1; idle(3);
        btn_c = 1'b1; idle(3);
        reset = 1'b1; game_state = 32'd0;
        step();
        btn_c = 1'b0;
        idle(2);
        reset = 1'b0;
        check_reset_outputs("rst_mid");
        idle(10);
        clear_counts();
        btn_c = 1'b1; idle(14);
        check("repress_pulses", pcnt[1], 1);
        check("repress_diff", difficulty, 32'd2);
        btn_c = 1'b0; idle(10);

        // random activity
        for (int seg = 0; seg < 80; seg++) begin
            {btn_r, btn_c, btn_l} = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) game_state = $urandom();
            if ($urandom_range(0, 19) == 0) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
            end
            idle($urandom_range(1, 12));
        end
        {btn_r, btn_c, btn_l} = 3'b000;
        idle(12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
